// File: rtl/control_unit.sv
//------------------------------------------------------------------------------
// Module   : control_unit
// Brief    : Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module control_unit #(
    parameter int OPW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ir,
    input  logic       zero,
    input  logic       carry,
    input  logic       mem_ready,
    output logic       ir_load,
    output logic       opr_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       addr_sel,
    output logic       acc_load,
    output logic       flag_load,
    output logic       acc_src,
    output logic [2:0] alu_op,
    output logic       write,
    output logic       illegal,
    output logic       halted
);

    localparam logic [2:0] c_FETCH   = 3'd0;
    localparam logic [2:0] c_DECODE  = 3'd1;
    localparam logic [2:0] c_OPERAND = 3'd2;
    localparam logic [2:0] c_EXEC    = 3'd3;
    localparam logic [2:0] c_HALT    = 3'd4;

    localparam logic [OPW-1:0] c_OP_NOP = OPW'(4'h0);
    localparam logic [OPW-1:0] c_OP_LDI = OPW'(4'h1);
    localparam logic [OPW-1:0] c_OP_LDA = OPW'(4'h2);
    localparam logic [OPW-1:0] c_OP_STA = OPW'(4'h3);
    localparam logic [OPW-1:0] c_OP_ADD = OPW'(4'h4);
    localparam logic [OPW-1:0] c_OP_SUB = OPW'(4'h5);
    localparam logic [OPW-1:0] c_OP_AND = OPW'(4'h6);
    localparam logic [OPW-1:0] c_OP_OR  = OPW'(4'h7);
    localparam logic [OPW-1:0] c_OP_XOR = OPW'(4'h8);
    localparam logic [OPW-1:0] c_OP_JMP = OPW'(4'h9);
    localparam logic [OPW-1:0] c_OP_JZ  = OPW'(4'hA);
    localparam logic [OPW-1:0] c_OP_JC  = OPW'(4'hB);
    localparam logic [OPW-1:0] c_OP_HLT = OPW'(4'hF);

    localparam logic [2:0] c_ALU_ADD  = 3'd0;
    localparam logic [2:0] c_ALU_SUB  = 3'd1;
    localparam logic [2:0] c_ALU_AND  = 3'd2;
    localparam logic [2:0] c_ALU_OR   = 3'd3;
    localparam logic [2:0] c_ALU_XOR  = 3'd4;
    localparam logic [2:0] c_ALU_PASS = 3'd5;

    logic [2:0]     r_state;
    logic [2:0]     w_next;
    logic [OPW-1:0] w_opcode;
    logic           w_two_byte;
    logic           w_illegal_op;
    logic           w_mem_exec;
    logic           w_unused;

    assign w_opcode = ir[7 -: OPW];
    assign w_unused = ^ir[7-OPW:0];

    assign w_two_byte   = (w_opcode >= c_OP_LDI) && (w_opcode <= c_OP_JC);
    assign w_illegal_op = (w_opcode > c_OP_JC) && (w_opcode != c_OP_HLT);
    assign w_mem_exec   = (w_opcode >= c_OP_LDA) && (w_opcode <= c_OP_XOR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_FETCH: begin
                if (mem_ready) w_next = c_DECODE;
            end
            c_DECODE: begin
                if (w_two_byte)                  w_next = c_OPERAND;
                else if (w_opcode == c_OP_HLT)   w_next = c_HALT;
                else                             w_next = c_FETCH;
            end
            c_OPERAND: begin
                if (mem_ready) w_next = c_EXEC;
            end
            c_EXEC: begin
                // Memory-referencing instructions stretch EXEC until the access completes.
                if (!w_mem_exec || mem_ready) w_next = c_FETCH;
            end
            c_HALT:  w_next = c_HALT;
            default: w_next = c_FETCH;
        endcase
    end

    // Outputs are gated by reset so that they, including write, drop asynchronously.
    always_comb begin
        ir_load   = 1'b0;
        opr_load  = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        addr_sel  = 1'b0;
        acc_load  = 1'b0;
        acc_src   = 1'b0;
        alu_op    = c_ALU_ADD;
        write     = 1'b0;
        illegal   = 1'b0;
        halted    = 1'b0;
        if (reset) begin
            case (r_state)
                c_FETCH: begin
                    ir_load = mem_ready;
                    pc_inc  = mem_ready;
                end
                c_DECODE: begin
                    illegal = w_illegal_op;
                end
                c_OPERAND: begin
                    opr_load = mem_ready;
                    pc_inc   = mem_ready;
                end
                c_EXEC: begin
                    case (w_opcode)
                        c_OP_LDI: begin
                            acc_load = 1'b1;
                            acc_src  = 1'b1;
                        end
                        c_OP_LDA: begin
                            addr_sel = 1'b1;
                            alu_op   = c_ALU_PASS;
                            acc_load = mem_ready;
                        end
                        c_OP_ADD: begin
                            addr_sel = 1'b1;
                            alu_op   = c_ALU_ADD;
                            acc_load = mem_ready;
                        end
                        c_OP_SUB: begin
                            addr_sel = 1'b1;
                            alu_op   = c_ALU_SUB;
                            acc_load = mem_ready;
                        end
                        c_OP_AND: begin
                            addr_sel = 1'b1;
                            alu_op   = c_ALU_AND;
                            acc_load = mem_ready;
                        end
                        c_OP_OR: begin
                            addr_sel = 1'b1;
                            alu_op   = c_ALU_OR;
                            acc_load = mem_ready;
                        end
                        c_OP_XOR: begin
                            addr_sel = 1'b1;
                            alu_op   = c_ALU_XOR;
                            acc_load = mem_ready;
                        end
                        c_OP_STA: begin
                            addr_sel = 1'b1;
                            write    = 1'b1;
                        end
                        c_OP_JMP: pc_load = 1'b1;
                        c_OP_JZ:  pc_load = zero;
                        c_OP_JC:  pc_load = carry;
                        c_OP_NOP: ;
                        default:  ;
                    endcase
                end
                c_HALT: begin
                    halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign flag_load = acc_load;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_control_unit
// Brief    : Directed self-checking bench for control_unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_unit;

    logic       clk;
    logic       reset;
    logic [7:0] ir;
    logic       zero;
    logic       carry;
    logic       mem_ready;
    logic       ir_load, opr_load, pc_inc, pc_load, addr_sel;
    logic       acc_load, flag_load, acc_src, write, illegal, halted;
    logic [2:0] alu_op;

    int n_vec;
    int n_err;

    control_unit #(.OPW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .ir        (ir),
        .zero      (zero),
        .carry     (carry),
        .mem_ready (mem_ready),
        .ir_load   (ir_load),
        .opr_load  (opr_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .addr_sel  (addr_sel),
        .acc_load  (acc_load),
        .flag_load (flag_load),
        .acc_src   (acc_src),
        .alu_op    (alu_op),
        .write     (write),
        .illegal   (illegal),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    logic [13:0] w_obs;
    assign w_obs = {ir_load, opr_load, pc_inc, pc_load, addr_sel, acc_load, flag_load,
                    acc_src, alu_op, write, illegal, halted};

    // Expected output vector; flag_load is always expected equal to acc_load.
    function automatic logic [13:0] ev(input logic irl, input logic oprl, input logic pci,
                                       input logic pcl, input logic asel, input logic accl,
                                       input logic asrc, input logic [2:0] op, input logic wr,
                                       input logic ill, input logic hlt);
        return {irl, oprl, pci, pcl, asel, accl, accl, asrc, op, wr, ill, hlt};
    endfunction

    task automatic chk(input string tag, input logic [13:0] exp);
        n_vec++;
        assert (w_obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, w_obs, exp);
        end
    endtask

    task automatic apply(input logic [7:0] irv, input logic mr, input logic z, input logic c);
        ir        = irv;
        mem_ready = mr;
        zero      = z;
        carry     = c;
        #1;
    endtask

    task automatic clk1;
        @(posedge clk);
        #1;
    endtask

    logic [13:0] e0, ef, eo, esta, eh, eill;
    logic [7:0]  alu_ir  [5];
    logic [2:0]  alu_exp [5];
    logic [7:0]  j_ir    [5];
    logic        j_z     [5];
    logic        j_c     [5];
    logic        j_pcl   [5];
    logic [7:0]  ill_ir  [3];

    initial begin
        clk = 1'b0; reset = 1'b0; ir = 8'h00; mem_ready = 1'b1; zero = 1'b0; carry = 1'b0;
        n_vec = 0; n_err = 0;
        e0   = '0;
        ef   = ev(1, 0, 1, 0, 0, 0, 0, 3'd0, 0, 0, 0);
        eo   = ev(0, 1, 1, 0, 0, 0, 0, 3'd0, 0, 0, 0);
        esta = ev(0, 0, 0, 0, 1, 0, 0, 3'd0, 1, 0, 0);
        eh   = ev(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 1);
        eill = ev(0, 0, 0, 0, 0, 0, 0, 3'd0, 0, 1, 0);
        alu_ir  = '{8'h2C, 8'h51, 8'h63, 8'h77, 8'h8E};
        alu_exp = '{3'd5, 3'd1, 3'd2, 3'd3, 3'd4};
        j_ir  = '{8'hA0, 8'hB0, 8'hA0, 8'hB0, 8'h90};
        j_z   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        j_c   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        j_pcl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ill_ir = '{8'hC0, 8'hD0, 8'hE0};
        #1;

        // Reset held: everything low even though FETCH with mem_ready=1 would strobe.
        for (int i = 0; i < 3; i++) begin
            apply(8'h00, 1, 0, 0); chk("reset_outputs", e0); clk1;
        end
        reset = 1'b1;
        apply(8'h00, 1, 0, 0); chk("rst_fetch1", ef); clk1;
        apply(8'h00, 1, 0, 0); chk("rst_decode", e0); clk1;
        apply(8'h00, 1, 0, 0); chk("rst_fetch3", ef); clk1;

        // LDI: EXEC ignores mem_ready.
        apply(8'h15, 1, 0, 0); chk("ldi_decode", e0); clk1;
        apply(8'h15, 1, 0, 0); chk("ldi_operand", eo); clk1;
        apply(8'h15, 0, 0, 0); chk("ldi_exec", ev(0, 0, 0, 0, 0, 1, 1, 3'd0, 0, 0, 0)); clk1;
        apply(8'h15, 1, 0, 0); chk("ldi_fetch", ef); clk1;

        // ADD
        apply(8'h42, 1, 0, 0); chk("add_decode", e0); clk1;
        apply(8'h42, 1, 0, 0); chk("add_operand", eo); clk1;
        apply(8'h42, 1, 0, 0); chk("add_exec", ev(0, 0, 0, 0, 1, 1, 0, 3'd0, 0, 0, 0)); clk1;

        // FETCH wait state
        apply(8'h42, 0, 0, 0); chk("fetch_wait", e0); clk1;
        apply(8'h42, 1, 0, 0); chk("fetch_after_wait", ef); clk1;

        // STA with OPERAND and EXEC wait states
        apply(8'h3A, 1, 0, 0); chk("sta_decode", e0); clk1;
        apply(8'h3A, 0, 0, 0); chk("sta_operand_wait", e0); clk1;
        apply(8'h3A, 1, 0, 0); chk("sta_operand", eo); clk1;
        apply(8'h3A, 0, 0, 0); chk("sta_write1", esta); clk1;
        apply(8'h3A, 0, 0, 0); chk("sta_write2", esta); clk1;
        apply(8'h3A, 1, 0, 0); chk("sta_write3", esta); clk1;
        apply(8'h3A, 1, 0, 0); chk("sta_fetch", ef); clk1;

        // LDA/SUB/AND/OR/XOR, one EXEC wait state each
        for (int i = 0; i < 5; i++) begin
            apply(alu_ir[i], 1, 0, 0); chk("alu_decode", e0); clk1;
            apply(alu_ir[i], 1, 0, 0); chk("alu_operand", eo); clk1;
            apply(alu_ir[i], 0, 0, 0);
            chk("alu_exec_wait", ev(0, 0, 0, 0, 1, 0, 0, alu_exp[i], 0, 0, 0)); clk1;
            apply(alu_ir[i], 1, 0, 0);
            chk("alu_exec", ev(0, 0, 0, 0, 1, 1, 0, alu_exp[i], 0, 0, 0)); clk1;
            apply(alu_ir[i], 1, 0, 0); chk("alu_fetch", ef); clk1;
        end

        // JZ/JC/JMP: single-cycle EXEC regardless of mem_ready
        for (int i = 0; i < 5; i++) begin
            apply(j_ir[i], 1, j_z[i], j_c[i]); chk("jmp_decode", e0); clk1;
            apply(j_ir[i], 1, j_z[i], j_c[i]); chk("jmp_operand", eo); clk1;
            apply(j_ir[i], 0, j_z[i], j_c[i]);
            chk("jmp_exec", ev(0, 0, 0, j_pcl[i], 0, 0, 0, 3'd0, 0, 0, 0)); clk1;
            apply(8'h00, 1, 0, 0); chk("jmp_fetch", ef); clk1;
        end

        // Illegal opcodes pulse illegal in DECODE only
        for (int i = 0; i < 3; i++) begin
            apply(ill_ir[i], 1, 0, 0); chk("illegal_decode", eill); clk1;
            apply(ill_ir[i], 1, 0, 0); chk("illegal_fetch", ef); clk1;
        end
        apply(8'h00, 1, 0, 0); chk("nop_decode", e0); clk1;
        apply(8'h00, 1, 0, 0); chk("nop_fetch", ef); clk1;

        // HLT then reset pulse
        apply(8'hF0, 1, 1, 1); chk("hlt_decode", e0); clk1;
        for (int i = 0; i < 12; i++) begin
            apply(8'hF0, logic'(i % 2), 1, 1); chk("halted", eh); clk1;
        end
        reset = 1'b0;
        #1; chk("halt_reset", e0); clk1;
        reset = 1'b1;
        apply(8'h00, 1, 0, 0); chk("post_halt_fetch", ef); clk1;

        // Reset during an STA write: write drops without a clock edge
        apply(8'h30, 1, 0, 0); chk("sta2_decode", e0); clk1;
        apply(8'h30, 1, 0, 0); chk("sta2_operand", eo); clk1;
        apply(8'h30, 0, 0, 0); chk("sta2_write", esta);
        reset = 1'b0;
        #1; chk("sta_abort_async", e0); clk1;
        apply(8'h30, 1, 0, 0); chk("sta_abort_held", e0);
        reset = 1'b1;
        apply(8'h00, 1, 0, 0); chk("abort_fetch", ef); clk1;
        apply(8'h00, 1, 0, 0); chk("abort_decode", e0); clk1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no end of sequence, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
